// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, T-state encoding
// and IR field positions, also used by the datapath/ALU side.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHL  = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01001;
  localparam logic [4:0] OP_OR   = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_NEG  = 5'b10000;
  localparam logic [4:0] OP_NOT  = 5'b10001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RA_HI  = 26;
  localparam int RA_LO  = 23;
  localparam int RB_HI  = 22;
  localparam int RB_LO  = 19;
  localparam int RC_HI  = 18;
  localparam int RC_LO  = 15;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd15
  } state_t;

  typedef enum logic [2:0] {
    CLS_3REG,
    CLS_MULDIV,
    CLS_UNARY,
    CLS_NOP,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_t;

  function automatic op_class_t op_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR:  return CLS_3REG;
      OP_MUL, OP_DIV:                 return CLS_MULDIV;
      OP_NEG, OP_NOT:                 return CLS_UNARY;
      OP_NOP:                         return CLS_NOP;
      OP_HALT:                        return CLS_HALT;
      default:                        return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/decoder_4_to_16.sv
// 4-bit index to one-hot 16 decoder with enable; all-zero output when disabled.
module decoder_4_to_16 (
  input  logic [3:0]  i_sel,
  input  logic        i_en,
  output logic [15:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_sel] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer driving the bus datapath strobes,
// register select enables and ALU opcode from the current T-state.
module control_sequencer
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        IncPC,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        LOin,
  output logic        HIin,
  output logic        read,
  output logic [15:0] rin,
  output logic [15:0] rout,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic        illegal,
  output logic [3:0]  t_state,
  output logic [15:0] instr_count
);

  state_t    r_state;
  logic      r_illegal;
  logic [15:0] r_count;

  logic [4:0] w_op;
  logic [3:0] w_ra, w_rb, w_rc;
  op_class_t  w_cls;
  logic [3:0] w_rin_sel, w_rout_sel;
  logic       w_rin_en, w_rout_en;
  logic       w_unused;

  assign w_op     = ir[OPC_HI:OPC_LO];
  assign w_ra     = ir[RA_HI:RA_LO];
  assign w_rb     = ir[RB_HI:RB_LO];
  assign w_rc     = ir[RC_HI:RC_LO];
  assign w_cls    = op_class(w_op);
  assign w_unused = ^ir[RC_LO-1:0];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state   <= S_IDLE;
      r_illegal <= 1'b0;
      r_count   <= '0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_T0;
        S_T0:   r_state <= S_T1;
        // Count on the T1->T2 edge so the new count is visible during T2.
        S_T1: if (mem_ready) begin
          r_state <= S_T2;
          r_count <= r_count + 16'd1;
        end
        S_T2:   r_state <= S_T3;
        S_T3: case (w_cls)
          CLS_3REG, CLS_MULDIV, CLS_UNARY: r_state <= S_T4;
          CLS_NOP:  r_state <= S_T0;
          CLS_HALT: r_state <= S_HALT;
          default: begin
            r_state   <= S_HALT;
            r_illegal <= 1'b1;
          end
        endcase
        S_T4:   r_state <= (w_cls == CLS_UNARY) ? S_T0 : S_T5;
        S_T5:   r_state <= (w_cls == CLS_MULDIV) ? S_T6 : S_T0;
        S_T6:   r_state <= S_T0;
        default: r_state <= S_HALT;
      endcase
    end
  end

  // IR is only loaded at the end of T2, so execute strobes decode the live ir
  // together with the registered state rather than being precomputed a cycle early.
  always_comb begin
    {PCout, IncPC, PCin, MARin, MDRout, IRin, Yin, Zin,
     Zlowout, Zhighout, LOin, HIin, read} = '0;
    w_rin_en   = 1'b0;
    w_rin_sel  = w_ra;
    w_rout_en  = 1'b0;
    w_rout_sel = w_rb;
    alu_op     = '0;
    case (r_state)
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; read = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: case (w_cls)
        CLS_3REG:   begin w_rout_en = 1'b1; Yin = 1'b1; end
        CLS_MULDIV: begin w_rout_en = 1'b1; w_rout_sel = w_ra; Yin = 1'b1; end
        CLS_UNARY:  begin w_rout_en = 1'b1; alu_op = w_op; Zin = 1'b1; end
        default: ;
      endcase
      S_T4: case (w_cls)
        CLS_3REG:   begin w_rout_en = 1'b1; w_rout_sel = w_rc; alu_op = w_op; Zin = 1'b1; end
        CLS_MULDIV: begin w_rout_en = 1'b1; alu_op = w_op; Zin = 1'b1; end
        CLS_UNARY:  begin Zlowout = 1'b1; w_rin_en = 1'b1; end
        default: ;
      endcase
      S_T5: case (w_cls)
        CLS_3REG:   begin Zlowout = 1'b1; w_rin_en = 1'b1; end
        CLS_MULDIV: begin Zlowout = 1'b1; LOin = 1'b1; end
        default: ;
      endcase
      S_T6: begin Zhighout = 1'b1; HIin = 1'b1; end
      default: ;
    endcase
  end

  assign MDRin       = (r_state == S_T1) && mem_ready;
  assign run         = (r_state != S_IDLE) && (r_state != S_HALT);
  assign illegal     = r_illegal;
  assign t_state     = r_state;
  assign instr_count = r_count;

  decoder_4_to_16 u_rin_dec (
    .i_sel    (w_rin_sel),
    .i_en     (w_rin_en),
    .o_onehot (rin)
  );

  decoder_4_to_16 u_rout_dec (
    .i_sel    (w_rout_sel),
    .i_en     (w_rout_en),
    .o_onehot (rout)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch, per-class execute strobes,
// memory wait, latencies, HALT/illegal handling and asynchronous clear.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] ir;
  logic        mem_ready;
  logic PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin, Yin, Zin;
  logic Zlowout, Zhighout, LOin, HIin, read;
  logic [15:0] rin, rout, instr_count;
  logic [4:0]  alu_op;
  logic        run, illegal;
  logic [3:0]  t_state;

  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [13:0] B_PCOUT  = 14'h2000;
  localparam logic [13:0] B_INCPC  = 14'h1000;
  localparam logic [13:0] B_PCIN   = 14'h0800;
  localparam logic [13:0] B_MARIN  = 14'h0400;
  localparam logic [13:0] B_MDRIN  = 14'h0200;
  localparam logic [13:0] B_MDROUT = 14'h0100;
  localparam logic [13:0] B_IRIN   = 14'h0080;
  localparam logic [13:0] B_YIN    = 14'h0040;
  localparam logic [13:0] B_ZIN    = 14'h0020;
  localparam logic [13:0] B_ZLOW   = 14'h0010;
  localparam logic [13:0] B_ZHIGH  = 14'h0008;
  localparam logic [13:0] B_LOIN   = 14'h0004;
  localparam logic [13:0] B_HIIN   = 14'h0002;
  localparam logic [13:0] B_READ   = 14'h0001;

  localparam logic [31:0] I_ADD  = 32'h1A920000; // ADD R5,R2,R4
  localparam logic [31:0] I_MUL  = 32'h71880000; // MUL R3,R1
  localparam logic [31:0] I_NOT  = 32'h8BB00000; // NOT R7,R6
  localparam logic [31:0] I_HALT = 32'hD8000000;

  logic [13:0] strb;
  logic [55:0] obs;
  logic [55:0] exp;

  assign strb = {PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin, Yin, Zin,
                 Zlowout, Zhighout, LOin, HIin, read};
  assign obs  = {t_state, strb, rin, rout, alu_op, run};

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .clr(clr), .ir(ir), .mem_ready(mem_ready),
    .PCout(PCout), .IncPC(IncPC), .PCin(PCin), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .LOin(LOin), .HIin(HIin), .read(read),
    .rin(rin), .rout(rout), .alu_op(alu_op), .run(run), .illegal(illegal),
    .t_state(t_state), .instr_count(instr_count)
  );

  // From a T0 sample point: advance through T1 and T2 with memory ready,
  // loading the IR word during T2 as the datapath would.
  task automatic fetch_to_t2(input logic [31:0] word);
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ir = word;
  endtask

  // From a T0 sample point: cycles until the next T0 (bounded).
  task automatic measure(input logic [31:0] word, output int lat);
    fetch_to_t2(word);
    lat = 3;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (t_state == 4'd1) return;
      lat++;
    end
    lat = 99;
  endtask

  task automatic test_reset();
    clr = 1'b1; mem_ready = 1'b1; ir = 32'h0;
    repeat (2) @(negedge clk);
    n_cmp++; if (obs !== 56'h0) begin n_fail++; $display("FAIL reset_outputs got=%h exp=%h", obs, 56'h0); end
    n_cmp++; if ({illegal, instr_count} !== 17'h0) begin n_fail++; $display("FAIL reset_status got=%h exp=%h", {illegal, instr_count}, 17'h0); end
    clr = 1'b0;
  endtask

  task automatic test_fetch();
    @(negedge clk);
    exp = {4'd1, B_PCOUT | B_INCPC | B_MARIN | B_ZIN, 32'h0, 5'd0, 1'b1};
    n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL fetch_T0 got=%h exp=%h", obs, exp); end
    @(negedge clk);
    exp = {4'd2, B_ZLOW | B_PCIN | B_READ | B_MDRIN, 32'h0, 5'd0, 1'b1};
    n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL fetch_T1 got=%h exp=%h", obs, exp); end
    @(negedge clk);
    exp = {4'd3, B_MDROUT | B_IRIN, 32'h0, 5'd0, 1'b1};
    n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL fetch_T2 got=%h exp=%h", obs, exp); end
    n_cmp++; if (instr_count !== 16'd1) begin n_fail++; $display("FAIL fetch_count got=%0d exp=1", instr_count); end
    ir = I_ADD;
  endtask

  task automatic test_add();
    @(negedge clk);
    exp = {4'd4, B_YIN, 16'h0000, 16'h0004, 5'd0, 1'b1};
    n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL add_T3 got=%h exp=%h", obs, exp); end
    @(negedge clk);
    exp = {4'd5, B_ZIN, 16'h0000, 16'h0010, 5'b00011, 1'b1};
    n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL add_T4 got=%h exp=%h", obs, exp); end
    @(negedge clk);
    exp = {4'd6, B_ZLOW, 16'h0020, 16'h0000, 5'd0, 1'b1};
    n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL add_T5 got=%h exp=%h", obs, exp); end
    @(negedge clk);
    exp = {4'd1, B_PCOUT | B_INCPC | B_MARIN | B_ZIN, 32'h0, 5'd0, 1'b1};
    n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL add_next_T0 got=%h exp=%h", obs, exp); end
  endtask

  task automatic test_mem_wait();
    int lat;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({t_state, MDRin, read, PCin, Zlowout} !== {4'd2, 4'b0111}) begin
        n_fail++; $display("FAIL wait_T1_%0d got=%h exp=%h", i, {t_state, MDRin, read, PCin, Zlowout}, {4'd2, 4'b0111});
      end
    end
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    n_cmp++; if ({t_state, MDRin} !== {4'd2, 1'b1}) begin n_fail++; $display("FAIL wait_ready got=%h exp=%h", {t_state, MDRin}, {4'd2, 1'b1}); end
    lat = 5;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (t_state == 4'd1) break;
      lat++;
    end
    n_cmp++; if (lat != 9) begin n_fail++; $display("FAIL wait_latency got=%0d exp=9", lat); end
    n_cmp++; if (instr_count !== 16'd2) begin n_fail++; $display("FAIL wait_count got=%0d exp=2", instr_count); end
  endtask

  task automatic test_mul();
    fetch_to_t2(I_MUL);
    @(negedge clk);
    exp = {4'd4, B_YIN, 16'h0000, 16'h0008, 5'd0, 1'b1};
    n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL mul_T3 got=%h exp=%h", obs, exp); end
    @(negedge clk);
    exp = {4'd5, B_ZIN, 16'h0000, 16'h0002, 5'b01110, 1'b1};
    n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL mul_T4 got=%h exp=%h", obs, exp); end
    @(negedge clk);
    exp = {4'd6, B_ZLOW | B_LOIN, 32'h0, 5'd0, 1'b1};
    n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL mul_T5 got=%h exp=%h", obs, exp); end
    @(negedge clk);
    exp = {4'd7, B_ZHIGH | B_HIIN, 32'h0, 5'd0, 1'b1};
    n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL mul_T6 got=%h exp=%h", obs, exp); end
    @(negedge clk);
    n_cmp++; if (t_state !== 4'd1) begin n_fail++; $display("FAIL mul_next_T0 got=%0d exp=1", t_state); end
  endtask

  task automatic test_not();
    fetch_to_t2(I_NOT);
    @(negedge clk);
    exp = {4'd4, B_ZIN, 16'h0000, 16'h0040, 5'b10001, 1'b1};
    n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL not_T3 got=%h exp=%h", obs, exp); end
    @(negedge clk);
    exp = {4'd5, B_ZLOW, 16'h0080, 16'h0000, 5'd0, 1'b1};
    n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL not_T4 got=%h exp=%h", obs, exp); end
    @(negedge clk);
    n_cmp++; if (t_state !== 4'd1) begin n_fail++; $display("FAIL not_next_T0 got=%0d exp=1", t_state); end
  endtask

  task automatic test_latency();
    int lat;
    measure(32'hD0000000, lat);
    n_cmp++; if (lat != 4) begin n_fail++; $display("FAIL lat_nop got=%0d exp=4", lat); end
    measure(32'h80000000, lat);
    n_cmp++; if (lat != 5) begin n_fail++; $display("FAIL lat_neg got=%0d exp=5", lat); end
    measure(32'h50000000, lat);
    n_cmp++; if (lat != 6) begin n_fail++; $display("FAIL lat_or got=%0d exp=6", lat); end
    measure(32'h78000000, lat);
    n_cmp++; if (lat != 7) begin n_fail++; $display("FAIL lat_div got=%0d exp=7", lat); end
  endtask

  task automatic test_halt();
    int bad;
    fetch_to_t2(I_HALT);
    @(negedge clk);
    exp = {4'd4, 14'h0, 32'h0, 5'd0, 1'b1};
    n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL halt_T3 got=%h exp=%h", obs, exp); end
    @(negedge clk);
    exp = {4'd15, 52'h0};
    n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL halt_enter got=%h exp=%h", obs, exp); end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      mem_ready = (i % 2 == 0);
      @(negedge clk);
      if (obs !== {4'd15, 52'h0}) bad++;
    end
    mem_ready = 1'b1;
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL halt_hold got=%0d bad cycles exp=0", bad); end
    n_cmp++; if ({illegal, instr_count} !== {1'b0, 16'd9}) begin n_fail++; $display("FAIL halt_status got=%h exp=%h", {illegal, instr_count}, {1'b0, 16'd9}); end
  endtask

  task automatic test_illegal();
    clr = 1'b1;
    #1;
    n_cmp++; if ({obs, instr_count} !== 72'h0) begin n_fail++; $display("FAIL clr_from_halt got=%h exp=0", {obs, instr_count}); end
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    fetch_to_t2(32'hF8000000);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if ({t_state, run, illegal} !== {4'd15, 1'b0, 1'b1}) begin n_fail++; $display("FAIL illegal_halt got=%h exp=%h", {t_state, run, illegal}, {4'd15, 1'b0, 1'b1}); end
    repeat (3) @(negedge clk);
    n_cmp++; if ({t_state, illegal} !== {4'd15, 1'b1}) begin n_fail++; $display("FAIL illegal_sticky got=%h exp=%h", {t_state, illegal}, {4'd15, 1'b1}); end
  endtask

  task automatic test_clr_mid();
    clr = 1'b1;
    @(negedge clk);
    n_cmp++; if ({illegal, instr_count} !== 17'h0) begin n_fail++; $display("FAIL clr_illegal got=%h exp=0", {illegal, instr_count}); end
    clr = 1'b0;
    @(negedge clk);
    fetch_to_t2(I_ADD);
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (t_state !== 4'd5) begin n_fail++; $display("FAIL pre_clr_T4 got=%0d exp=5", t_state); end
    #2;
    clr = 1'b1;
    #1;
    n_cmp++; if ({obs, illegal, instr_count} !== 73'h0) begin n_fail++; $display("FAIL clr_mid_T4 got=%h exp=0", {obs, illegal, instr_count}); end
    @(negedge clk);
    n_cmp++; if (obs !== 56'h0) begin n_fail++; $display("FAIL clr_hold got=%h exp=0", obs); end
    clr = 1'b0;
    @(negedge clk);
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (t_state !== 4'd2) begin n_fail++; $display("FAIL pre_clr_T1 got=%0d exp=2", t_state); end
    clr = 1'b1;
    #1;
    n_cmp++; if ({obs, instr_count} !== 72'h0) begin n_fail++; $display("FAIL clr_in_wait got=%h exp=0", {obs, instr_count}); end
    @(negedge clk);
    clr = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    exp = {4'd1, B_PCOUT | B_INCPC | B_MARIN | B_ZIN, 32'h0, 5'd0, 1'b1};
    n_cmp++; if (obs !== exp) begin n_fail++; $display("FAIL restart_T0 got=%h exp=%h", obs, exp); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_add();
    test_mem_wait();
    test_mul();
    test_not();
    test_latency();
    test_halt();
    test_illegal();
    test_clr_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the 32-bit bus-based datapath. It fetches instructions via the PC/MAR/MDR/IR path and decodes the IR opcode. It steps through per-instruction T-states, driving every register-in/out strobe, the read strobe and the 5-bit ALU opcode into the datapath. It sits directly upstream of the datapath and replaces the testbench that currently drives those strobes by hand.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge.
- clr  in  1  asynchronous, active-high reset.
- ir  in  32  IR contents. Fields: opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15].
- mem_ready  in  1  memory has valid Mdatain this cycle.
- PCout, IncPC, PCin, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, LOin, HIin, read  out  1 each  datapath strobes.
- rin  out  16  one-hot R0–R15 load enable (all-zero when none).
- rout  out  16  one-hot R0–R15 bus drive (all-zero when none).
- alu_op  out  5  ALU opcode; 00000 when no ALU operation is active.
- run  out  1  high while executing; low in IDLE and HALT.
- illegal  out  1  sticky; set when an undefined opcode is decoded.
- t_state  out  4  current state code, for debug.
- instr_count  out  16  number of completed fetches; wraps 0xFFFF→0.

## Operation
- Opcodes: ADD 00011, SUB 00100, SHR 00101, SHL 00110, ROR 00111, ROL 01000, AND 01001, OR 01010, MUL 01110, DIV 01111, NEG 10000, NOT 10001, NOP 11010, HALT 11011. All other opcodes are illegal.
- States: IDLE, T0–T6, HALT.
- IDLE → T0 unconditionally.
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, read are held every cycle. MDRin = mem_ready (Mealy). Stay in T1 while mem_ready=0; go to T2 when mem_ready=1.
- T2: MDRout, IRin; instr_count increments. Next state is T3.
- T3 decodes ir, which is stable from here on:
  - Three-register ops (ADD, SUB, SHR, SHL, ROR, ROL, AND, OR):
    - T3: rout[Rb], Yin.
    - T4: rout[Rc], alu_op=opcode, Zin.
    - T5: Zlowout, rin[Ra].
    - Then → T0.
  - MUL/DIV:
    - T3: rout[Ra], Yin.
    - T4: rout[Rb], alu_op, Zin.
    - T5: Zlowout, LOin.
    - T6: Zhighout, HIin.
    - Then → T0.
  - NEG/NOT:
    - T3: rout[Rb], alu_op, Zin.
    - T4: Zlowout, rin[Ra].
    - Then → T0.
  - NOP: T3 has no strobes, then → T0.
  - HALT: T3 → HALT.
  - Illegal opcode: T3 sets illegal, then → HALT.
- HALT: all strobes 0, run=0. Only clr leaves HALT.
- Strobe rules:
  - Except MDRin, all strobes are registered-state Moore outputs.
  - At most one bus driver (PCout, MDRout, Zlowout, Zhighout, rout bit) is asserted per cycle.
  - rin and rout each have at most one bit set.

## Timing
- Reset: state=IDLE; all strobes, rin, rout, alu_op, run, illegal, instr_count = 0; t_state=0. Reset takes effect immediately and asynchronously, including mid-instruction and during a T1 wait.
- First T0 is on the first rising edge after clr deasserts; run=1 from T0 onward.
- Instruction latency with mem_ready tied high: 6 cycles for three-register ops, 7 for MUL/DIV, 5 for NEG/NOT, 4 for NOP.
- Each T1 wait cycle adds 1 cycle of latency.
- mem_ready is ignored outside T1.
- Register operands use a single decode (Ra=Rb=Rc allowed); no hazards arise because execution is strictly sequential.

## Structure
- Shared package cpu_ctrl_pkg holds:
  - opcode localparams (shared with the datapath/ALU);
  - state encoding;
  - IR field bit positions.
- One sub-module, decoder_4_to_16 (4-bit index plus enable → one-hot 16), instantiated for rin and rout.

## Test plan
- Reset/fetch: clr high then low, mem_ready=1 → IDLE, then T0 with PCout=MARin=IncPC=Zin=1. T1 has read=MDRin=PCin=1. T2 has IRin=1 and instr_count=1.
- ADD R5,R2,R4 (ir=0x1A920000), mem_ready=1:
  - T3: rout=0x0004, Yin.
  - T4: rout=0x0010, alu_op=00011, Zin.
  - T5: rin=0x0020, Zlowout.
  - Next cycle is T0.
- Memory wait: mem_ready=0 for 3 cycles in T1 → T1 held 4 cycles; MDRin high only in the 4th; total ADD latency 9.
- MUL R3,R1 (ir=0x71880000) → T5 has LOin+Zlowout, T6 has HIin+Zhighout, and rin=0 throughout.
- NOT R7,R6 (ir=0x8BB00000) → T3 has rout=0x0040, alu_op=10001, Zin; T4 has rin=0x0080.
- HALT (0xD8000000) → run=0, stays halted for 100 cycles. Opcode 11111 → illegal=1 and HALT. clr asserted mid-T4 → immediate IDLE with all outputs 0.
